// File: rtl/led_sweep_scheduler.sv
// rtl/led_sweep_scheduler.sv - round-robin shared LED bank pattern sequencer
// Optional hold-to-play abort: define LED_ABORT_ON_RELEASE_EN.
module led_sweep_scheduler #(
    parameter int N_REQ    = 4,
    parameter int NUM_LED  = 8,
    parameter int STEP_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    output logic [NUM_LED-1:0] led,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               done,
    output logic               abort
);
    localparam int IDX_W  = $clog2(N_REQ);
    localparam int STEP_W = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
    localparam int DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [N_REQ-1:0]   req_q;
    logic [N_REQ-1:0]   pending_q, pending_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   own_q, own_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [NUM_LED-1:0] led_q, led_d;
    logic               done_q, done_d;

    logic [N_REQ-1:0]   rise;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   idx_v;
    logic               div_end;
    logic               rel;

    function automatic logic [NUM_LED-1:0] pat(input logic [IDX_W-1:0] g,
                                               input logic [STEP_W-1:0] s);
        logic [NUM_LED-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            case (int'(g) % 4)
                0:       r[i] = (i == int'(s));
                1:       r[i] = (i == NUM_LED - 1 - int'(s));
                2:       r[i] = (i <= int'(s));
                default: r[i] = ((i % 2) == (int'(s) % 2));
            endcase
        end
        return r;
    endfunction

    assign rise    = req & ~req_q;
    assign div_end = (div_q == DIV_W'(STEP_DIV - 1));
    assign busy    = (state_q == ST_RUN) || (state_q == ST_GAP);
    assign led     = led_q;
    assign grant   = grant_q;
    assign done    = done_q;

`ifdef LED_ABORT_ON_RELEASE_EN
    logic abort_q;
    assign rel   = busy && !req_q[own_q];
    assign abort = abort_q;
`else
    assign rel   = 1'b0;
    assign abort = 1'b0;
`endif

    // Walk downward so the nearest pending index after last_q wins.
    always_comb begin
        pick  = '0;
        idx_v = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx_v = IDX_W'((int'(last_q) + i) % N_REQ);
            if (pending_q[idx_v]) pick = idx_v;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | rise;
        grant_d   = grant_q;
        own_d     = own_q;
        last_d    = last_q;
        step_d    = step_q;
        div_d     = div_q;
        led_d     = led_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    own_d     = pick;
                    grant_d   = N_REQ'(1) << pick;
                    pending_d = (pending_q & ~(N_REQ'(1) << pick)) | rise;
                    step_d    = '0;
                    div_d     = '0;
                    led_d     = pat(pick, '0);
                    state_d   = ST_RUN;
                end
            end
            ST_RUN, ST_GAP: begin
                if (rel) begin
                    led_d   = '0;
                    grant_d = '0;
                    last_d  = own_q;
                    div_d   = '0;
                    state_d = ST_IDLE;
                end else if (!div_end) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (state_q == ST_GAP) begin
                        grant_d = '0;
                        last_d  = own_q;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (step_q != STEP_W'(NUM_LED - 1)) begin
                        step_d = step_q + STEP_W'(1);
                        led_d  = pat(own_q, step_q + STEP_W'(1));
                    end else begin
                        led_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                led_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            pending_q <= '0;
            grant_q   <= '0;
            own_q     <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            step_q    <= '0;
            div_q     <= '0;
            led_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            own_q     <= own_d;
            last_q    <= last_d;
            step_q    <= step_d;
            div_q     <= div_d;
            led_q     <= led_d;
            done_q    <= done_d;
        end
    end

`ifdef LED_ABORT_ON_RELEASE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) abort_q <= 1'b0;
        else     abort_q <= rel;
    end
`endif

endmodule
